// File: rtl/hud_pkg.sv
// hud_pkg: shared HUD types (health FSM states, 3-digit BCD) and a constant BCD helper
package hud_pkg;

    typedef enum logic [1:0] {ALIVE, HIT, INVULN, DEAD} health_state_t;

    typedef struct packed {
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd3_t;

    function automatic bcd3_t bcd_const(input int v);
        bcd3_t b;
        b.hundreds = 4'((v / 100) % 10);
        b.tens     = 4'((v / 10) % 10);
        b.ones     = 4'(v % 10);
        return b;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble, 1 load cycle plus W shift cycles
//  clk, reset_n : clock, async active-low reset
//  start, bin   : load bin and (re)start a conversion, even while busy
//  busy, done   : conversion running / one-cycle completion strobe
//  bcd          : last completed result, held between conversions
module bin2bcd_seq
    import hud_pkg::*;
#(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         busy,
    output logic         done,
    output bcd3_t        bcd
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  sh;
    logic [11:0]   acc;
    logic [11:0]   adj;
    logic [CW-1:0] cnt;

    // add 3 to every digit that is 5 or more before shifting
    always_comb begin
        adj = acc;
        for (int i = 0; i < 3; i++)
            adj[i*4 +: 4] = (acc[i*4 +: 4] >= 4'd5) ? acc[i*4 +: 4] + 4'd3 : acc[i*4 +: 4];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh   <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            bcd  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sh   <= bin;
                acc  <= '0;
                cnt  <= CW'(W);
                busy <= 1'b1;
            end else if (busy) begin
                acc <= {adj[10:0], sh[W-1]};
                sh  <= sh << 1;
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    bcd  <= {adj[10:0], sh[W-1]};
                end
            end
        end
    end

endmodule

// File: rtl/health_controller.sv
// health_controller: player health, hit invulnerability and game-over for the HUD
//  clk, reset_n               : clock, async active-low reset
//  vsync, player_collision    : async inputs, 2-FF synchronised, rising edge = frame tick / hit
//  heal_req, restart          : synchronous single-cycle pulses
//  health_hundreds/tens/ones  : BCD digits, updated together when a conversion finishes
//  health_bin                 : binary health
//  invuln, blink, hit_pulse, game_over : status outputs
module health_controller
    import hud_pkg::*;
#(
    parameter int MAX_HEALTH = 100,
    parameter int DAMAGE     = 20,
    parameter int HEAL       = 10,
    parameter int IFRAMES    = 60,
    parameter int BLINK_BIT  = 2,
    localparam int HW        = $clog2(MAX_HEALTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          vsync,
    input  logic          player_collision,
    input  logic          heal_req,
    input  logic          restart,
    output logic [3:0]    health_hundreds,
    output logic [3:0]    health_tens,
    output logic [3:0]    health_ones,
    output logic [HW-1:0] health_bin,
    output logic          invuln,
    output logic          blink,
    output logic          hit_pulse,
    output logic          game_over
);

    // counter is wide enough for IFRAMES and for the blink tap
    localparam int IW = ($clog2(IFRAMES + 1) > BLINK_BIT) ? $clog2(IFRAMES + 1) : BLINK_BIT + 1;

    logic [2:0]    vs_s;
    logic [2:0]    col_s;
    logic          frame_tick;
    logic          hit_evt;
    health_state_t state;
    health_state_t state_nxt;
    logic [HW-1:0] health;
    logic [HW-1:0] health_nxt;
    logic [HW-1:0] healed;
    logic [HW-1:0] damaged;
    logic [IW-1:0] iframe_cnt;
    logic [IW-1:0] iframe_nxt;
    logic          conv_start;
    logic          conv_busy;
    logic          conv_done;
    bcd3_t         conv_bcd;
    bcd3_t         digits;

    // two sync flops plus one history flop for rising-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_s  <= '0;
            col_s <= '0;
        end else begin
            vs_s  <= {vs_s[1:0], vsync};
            col_s <= {col_s[1:0], player_collision};
        end
    end

    assign frame_tick = vs_s[1] & ~vs_s[2];
    assign hit_evt    = col_s[1] & ~col_s[2];

    assign damaged = (32'(health) > 32'(DAMAGE)) ? health - HW'(DAMAGE) : '0;
    assign healed  = (32'(health) + 32'(HEAL) >= 32'(MAX_HEALTH)) ? HW'(MAX_HEALTH) : health + HW'(HEAL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ALIVE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (restart) state_nxt = ALIVE;
        else begin
            case (state)
                ALIVE:   if (hit_evt) state_nxt = HIT;
                HIT:     state_nxt = (damaged == '0) ? DEAD : INVULN;
                INVULN:  if (frame_tick && iframe_cnt == IW'(1)) state_nxt = ALIVE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        invuln    = state == INVULN;
        game_over = state == DEAD;
        hit_pulse = state == HIT;
        blink     = (state == INVULN) ? iframe_cnt[BLINK_BIT] : 1'b1;
    end

    // a heal loses to a hit arriving in the same ALIVE cycle and is not retried
    always_comb begin
        health_nxt = restart ? HW'(MAX_HEALTH) :
                     (state == HIT) ? damaged :
                     (((state == ALIVE && !hit_evt) || state == INVULN) && heal_req) ? healed :
                     health;
        iframe_nxt = restart ? '0 :
                     (state == HIT && damaged != '0) ? IW'(IFRAMES) :
                     (state == INVULN && frame_tick && iframe_cnt != '0) ? iframe_cnt - 1'b1 :
                     iframe_cnt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            health     <= HW'(MAX_HEALTH);
            iframe_cnt <= '0;
        end else begin
            health     <= health_nxt;
            iframe_cnt <= iframe_nxt;
        end
    end

    // converter loads the value health is about to take, so the latest change always wins
    assign conv_start = (health_nxt != health) || (restart && conv_busy);

    bin2bcd_seq #(.W(HW)) u_bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (conv_start),
        .bin     (health_nxt),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd     (conv_bcd)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       digits <= bcd_const(MAX_HEALTH);
        else if (conv_done) digits <= conv_bcd;
    end

    assign health_hundreds = digits.hundreds;
    assign health_tens     = digits.tens;
    assign health_ones     = digits.ones;
    assign health_bin      = health;

endmodule

// File: tb/tb_health_controller.sv
// tb_health_controller: randomized and directed scoreboard bench for health_controller
module tb_health_controller;

    localparam int MAXH  = 100;
    localparam int DMG   = 20;
    localparam int HEALV = 10;
    localparam int IFR   = 60;
    localparam int HW    = 7;

    logic          clk = 0, reset_n = 0, vsync = 0, collision = 0, heal_req = 0, restart = 0;
    logic [3:0]    hund, tens, ones;
    logic [HW-1:0] health_bin;
    logic          invuln, blink, hit_pulse, game_over;

    health_controller dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .vsync            (vsync),
        .player_collision (collision),
        .heal_req         (heal_req),
        .restart          (restart),
        .health_hundreds  (hund),
        .health_tens      (tens),
        .health_ones      (ones),
        .health_bin       (health_bin),
        .invuln           (invuln),
        .blink            (blink),
        .hit_pulse        (hit_pulse),
        .game_over        (game_over)
    );

    always #5 clk = ~clk;

    int            checks = 0, errors = 0;
    int            exp_q[$];
    logic [11:0]   dig_q[$];
    int            mh = MAXH, miframes = 0, exp_hits = 0, mon_hits = 0, age = 0;
    bit            mdead = 0, mon_en = 0, last_hp = 0;
    logic [HW-1:0] last_h = HW'(MAXH);
    logic [11:0]   last_d = 12'h100;

    function automatic logic [11:0] to_bcd(int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_set(int nh, bit dig);
        if (nh != mh) begin
            exp_q.push_back(nh);
            if (dig) dig_q.push_back(to_bcd(nh));
        end
        mh = nh;
    endtask

    task automatic model_hit();
        if (!mdead && miframes == 0) begin
            exp_hits++;
            model_set(mh > DMG ? mh - DMG : 0, 1);
            if (mh == 0) mdead = 1;
            else miframes = IFR;
        end
    endtask

    task automatic check_status(string tag);
        @(negedge clk);
        chk({tag, "_invuln"}, invuln, (!mdead && miframes > 0));
        chk({tag, "_game_over"}, game_over, mdead);
        chk({tag, "_blink"}, blink, (!mdead && miframes > 0) ? (miframes >> 2) & 1 : 1);
        chk({tag, "_health"}, health_bin, mh);
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a new health or digit value
    always @(negedge clk) begin
        if (mon_en) begin
            age++;
            if (hit_pulse === 1'b1) begin
                mon_hits++;
                chk("hit_pulse_width", last_hp, 0);
            end
            last_hp = (hit_pulse === 1'b1);
            if (health_bin !== last_h) begin
                if (exp_q.size() == 0) chk("health_unexpected", health_bin, last_h);
                else chk("health", health_bin, exp_q.pop_front());
                last_h = health_bin;
                age = 0;
            end
            if ({hund, tens, ones} !== last_d) begin
                if (dig_q.size() == 0) chk("digits_unexpected", {hund, tens, ones}, last_d);
                else chk("digits", {hund, tens, ones}, dig_q.pop_front());
                chk("digit_latency", age <= HW + 2, 1);
                last_d = {hund, tens, ones};
            end
        end
    end

    task automatic do_hit(int hold);
        @(posedge clk); #1 collision = 1;
        model_hit();
        repeat (hold) @(posedge clk);
        #1 collision = 0;
        repeat (14) @(posedge clk);
        check_status("hit");
    endtask

    task automatic do_heal();
        @(posedge clk); #1 heal_req = 1;
        if (!mdead) model_set(mh + HEALV > MAXH ? MAXH : mh + HEALV, 1);
        @(posedge clk); #1 heal_req = 0;
        repeat (12) @(posedge clk);
        check_status("heal");
    endtask

    task automatic do_restart();
        @(posedge clk); #1 restart = 1;
        model_set(MAXH, 1);
        miframes = 0;
        mdead = 0;
        @(posedge clk); #1 restart = 0;
        repeat (12) @(posedge clk);
        check_status("restart");
    endtask

    task automatic do_frames(int n);
        repeat (n) begin
            @(posedge clk); #1 vsync = 1;
            if (miframes > 0) miframes--;
            repeat (3) @(posedge clk);
            #1 vsync = 0;
            repeat (4) @(posedge clk);
            check_status("frame");
        end
    endtask

    task automatic wait_hit_pulse();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (hit_pulse === 1'b1);
        end
        chk("hit_pulse_seen", seen, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 mon_en = 1;
        check_status("reset");
        chk("reset_digits", {hund, tens, ones}, 12'h100);
        chk("reset_hit_pulse", hit_pulse, 0);
        @(posedge clk); #1 reset_n = 1;

        // single hit and exact invulnerability window
        do_hit(2);
        chk("first_hit_count", exp_hits, 1);
        do_frames(IFR);

        // re-pulses during invulnerability, then a level held for 200 frames
        do_hit(3);
        do_hit(5);
        do_frames(10);
        do_hit(1);
        do_frames(IFR - 10);
        @(posedge clk); #1 collision = 1;
        model_hit();
        repeat (20) @(posedge clk);
        do_frames(200);
        #1 collision = 0;
        repeat (10) @(posedge clk);

        // five hits to death, then ignored events
        do_restart();
        repeat (5) begin
            do_hit(2);
            do_frames(IFR);
        end
        do_hit(2);
        do_heal();

        // heal saturation and hit-beats-heal in the same cycle
        do_restart();
        do_hit(2);
        do_frames(IFR);
        do_heal();
        @(posedge clk); #1 collision = 1;
        model_hit();
        @(posedge clk);
        @(posedge clk); #1 heal_req = 1;
        @(posedge clk); #1 heal_req = 0; collision = 0;
        repeat (14) @(posedge clk);
        check_status("hit_heal_same_cycle");
        do_frames(IFR);
        repeat (4) do_heal();

        // restart during invulnerability
        do_hit(2);
        do_frames(10);
        do_restart();

        // restart while the 80 conversion is still running
        @(posedge clk); #1 collision = 1;
        exp_hits++;
        model_set(MAXH - DMG, 0);
        wait_hit_pulse();
        collision = 0;
        repeat (4) @(posedge clk);
        #1 restart = 1;
        model_set(MAXH, 0);
        @(posedge clk); #1 restart = 0;
        repeat (15) @(posedge clk);
        check_status("abort");
        chk("abort_digits", {hund, tens, ones}, 12'h100);

        // asynchronous reset while in HIT
        do_hit(2);
        do_frames(IFR);
        @(posedge clk); #1 collision = 1;
        exp_hits++;
        wait_hit_pulse();
        #2 model_set(MAXH, 1);
        miframes = 0;
        mdead = 0;
        reset_n = 0;
        collision = 0;
        #1;
        chk("async_rst_health", health_bin, MAXH);
        chk("async_rst_digits", {hund, tens, ones}, 12'h100);
        chk("async_rst_invuln", invuln, 0);
        chk("async_rst_blink", blink, 1);
        chk("async_rst_hit_pulse", hit_pulse, 0);
        chk("async_rst_game_over", game_over, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        repeat (5) @(posedge clk);

        // randomized mix
        repeat (120) begin
            case ($urandom_range(0, 11))
                0, 1, 2: do_hit($urandom_range(1, 30));
                3, 4, 5: do_heal();
                6:       do_restart();
                default: do_frames($urandom_range(1, 25));
            endcase
        end

        repeat (20) @(posedge clk);
        chk("health_queue_empty", exp_q.size(), 0);
        chk("digit_queue_empty", dig_q.size(), 0);
        chk("hit_count", mon_hits, exp_hits);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
